factor_engine: RTL and testbench



---
 rtl/factor_engine_pkg.sv | 29 ++
 rtl/factor_engine_if.sv | 37 +++
 rtl/factor_engine_serial_divider.sv | 72 +++++++
 rtl/factor_engine.sv | 164 ++++++++++++++++
 tb/tb_factor_engine.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/factor_engine_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : factor_pkg
//  Purpose : Shared types and constants for the trial-division factorizer:
//            FSM state encoding, divisor/square seeds, count-width helper.
//  Revision: 1.0 - initial release
// ============================================================================
package factor_pkg;

  // Top-level factorizer states (explicit 3-bit encoding).
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CHECK   = 3'd1,
    ST_DIV     = 3'd2,
    ST_RESOLVE = 3'd3,
    ST_EMIT    = 3'd4
  } state_t;

  // Trial division always starts at 2, whose square is 4.
  localparam int FIRST_DIVISOR = 2;
  localparam int FIRST_SQUARE  = 4;

  // Bits needed to count up to WIDTH factors (2^WIDTH-ish operands).
  function automatic int count_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/factor_engine_if.sv
`default_nettype none
// ============================================================================
//  Module  : factor_engine_if
//  Purpose : Start/operand request plus valid/ready factor stream between the
//            input-capture logic (master) and the factorizer (slave).
//  Revision: 1.0 - initial release
// ============================================================================
interface factor_engine_if
  import factor_pkg::*;
#(
  parameter int WIDTH = 8
);

  localparam int CW = count_width(WIDTH);

  logic             start;
  logic [WIDTH-1:0] value;
  logic             busy;
  logic             factor_valid;
  logic             factor_ready;
  logic [WIDTH-1:0] factor;
  logic             factor_last;
  logic             is_prime;
  logic [CW-1:0]    count;

  modport master (
    output start, value, factor_ready,
    input  busy, factor_valid, factor, factor_last, is_prime, count
  );

  modport slave (
    input  start, value, factor_ready,
    output busy, factor_valid, factor, factor_last, is_prime, count
  );

endinterface
`default_nettype wire

// File: rtl/factor_engine_serial_divider.sv
`default_nettype none
// ============================================================================
//  Module  : serial_divider
//  Purpose : Restoring divider, one quotient bit per clock. A load starts a
//            WIDTH-cycle run; done_o is high in the last step cycle, so the
//            quotient/remainder outputs are final on the following cycle.
//  Revision: 1.0 - initial release
// ============================================================================
module serial_divider
  import factor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o
);

  localparam int CW = count_width(WIDTH);

  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] div_q;
  logic [CW-1:0]    cnt_q;

  logic [WIDTH:0]   rem_shift;
  logic [WIDTH-1:0] rem_sub;
  logic             sub_ok;

  // One restoring step: shift next dividend bit in, subtract if it fits.
  // The true difference is below the divisor, so WIDTH bits suffice.
  always_comb begin
    rem_shift = {rem_q, quot_q[WIDTH-1]};
    sub_ok    = (rem_shift >= {1'b0, div_q});
    rem_sub   = rem_shift[WIDTH-1:0] - div_q;
  end

  // Shift/subtract datapath with a down-counter pacing WIDTH steps.
  always_ff @(posedge clk) begin
    if (rst) begin
      quot_q <= '0;
      rem_q  <= '0;
      div_q  <= '0;
      cnt_q  <= '0;
    end else if (load_i) begin
      quot_q <= dividend_i;
      rem_q  <= '0;
      div_q  <= divisor_i;
      cnt_q  <= CW'(WIDTH);
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CW'(1);
      if (sub_ok) begin
        rem_q  <= rem_sub;
        quot_q <= {quot_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_q  <= rem_shift[WIDTH-1:0];
        quot_q <= {quot_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  assign done_o      = (cnt_q == CW'(1));
  assign quotient_o  = quot_q;
  assign remainder_o = rem_q;

endmodule
`default_nettype wire

// File: rtl/factor_engine.sv
`default_nettype none
// ============================================================================
//  Module  : factor_engine
//  Purpose : Trial-division prime factorizer. Streams prime factors of a
//            WIDTH-bit operand in non-decreasing order over valid/ready,
//            with last/prime flags and a running factor count.
//  Revision: 1.0 - initial release
// ============================================================================
module factor_engine
  import factor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  factor_engine_if.slave  fe
);

  localparam int CW  = count_width(WIDTH);
  localparam int SQW = 2 * WIDTH;

  state_t           state_q,  state_d;
  logic [WIDTH-1:0] r_q,      r_d;
  logic [WIDTH-1:0] d_q,      d_d;
  logic [SQW-1:0]   sq_q,     sq_d;
  logic [CW-1:0]    count_q,  count_d;
  logic [WIDTH-1:0] factor_q, factor_d;
  logic             last_q,   last_d;
  logic             prime_q,  prime_d;

  logic             div_load;
  logic             div_done;
  logic [WIDTH-1:0] div_quot;
  logic [WIDTH-1:0] div_rem;

  serial_divider #(
    .WIDTH (WIDTH)
  ) u_div (
    .clk         (clk),
    .rst         (rst),
    .load_i      (div_load),
    .dividend_i  (r_q),
    .divisor_i   (d_q),
    .done_o      (div_done),
    .quotient_o  (div_quot),
    .remainder_o (div_rem)
  );

  // State and datapath registers; reset drops any in-flight factor.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      r_q      <= '0;
      d_q      <= '0;
      sq_q     <= '0;
      count_q  <= '0;
      factor_q <= '0;
      last_q   <= 1'b0;
      prime_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      r_q      <= r_d;
      d_q      <= d_d;
      sq_q     <= sq_d;
      count_q  <= count_d;
      factor_q <= factor_d;
      last_q   <= last_d;
      prime_q  <= prime_d;
    end
  end

  // Next-state logic; divisor advance uses (d+2)^2 = d^2 + 4d + 4 so no
  // multiplier is needed, with the 2 -> 3 step special-cased (+5).
  always_comb begin
    state_d  = state_q;
    r_d      = r_q;
    d_d      = d_q;
    sq_d     = sq_q;
    count_d  = count_q;
    factor_d = factor_q;
    last_d   = last_q;
    prime_d  = prime_q;
    div_load = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (fe.start) begin
          r_d     = fe.value;
          d_d     = WIDTH'(FIRST_DIVISOR);
          sq_d    = SQW'(FIRST_SQUARE);
          count_d = '0;
          if (fe.value < WIDTH'(2)) begin
            // 0 and 1 are passed through as a single non-prime "factor".
            state_d  = ST_EMIT;
            factor_d = fe.value;
            last_d   = 1'b1;
            prime_d  = 1'b0;
          end else begin
            state_d = ST_CHECK;
          end
        end
      end

      ST_CHECK: begin
        if (sq_q > {{WIDTH{1'b0}}, r_q}) begin
          // No divisor up to sqrt(r) remains: r itself is the last prime.
          state_d  = ST_EMIT;
          factor_d = r_q;
          last_d   = 1'b1;
          prime_d  = (count_q == '0);
        end else begin
          state_d  = ST_DIV;
          div_load = 1'b1;
        end
      end

      ST_DIV: begin
        if (div_done) begin
          state_d = ST_RESOLVE;
        end
      end

      ST_RESOLVE: begin
        if (div_rem == '0) begin
          state_d  = ST_EMIT;
          factor_d = d_q;
          last_d   = 1'b0;
          prime_d  = 1'b0;
          r_d      = div_quot;
        end else begin
          state_d = ST_CHECK;
          if (d_q == WIDTH'(FIRST_DIVISOR)) begin
            d_d  = WIDTH'(3);
            sq_d = sq_q + SQW'(5);
          end else begin
            d_d  = d_q + WIDTH'(2);
            sq_d = sq_q + {{(WIDTH-2){1'b0}}, d_q, 2'b00} + SQW'(4);
          end
        end
      end

      ST_EMIT: begin
        if (fe.factor_ready) begin
          count_d = count_q + CW'(1);
          // Keep d on a non-last factor so repeated primes are found.
          state_d = last_q ? ST_IDLE : ST_CHECK;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign fe.busy         = (state_q != ST_IDLE);
  assign fe.factor_valid = (state_q == ST_EMIT);
  assign fe.factor       = factor_q;
  assign fe.factor_last  = last_q;
  assign fe.is_prime     = prime_q;
  assign fe.count        = count_q;

endmodule
`default_nettype wire

// File: tb/tb_factor_engine.sv
`default_nettype none
// ============================================================================
//  Module  : tb_factor_engine
//  Purpose : Directed self-checking bench for factor_engine at WIDTH 8, 16
//            and 17 (65536 = 2^16 needs 17 bits to be representable).
//  Revision: 1.0 - initial release
// ============================================================================
module tb_factor_engine;

  typedef logic [31:0] fac_t [16];

  localparam int BUDGET = 6000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  sel = 2'd0;
  logic        tb_start = 1'b0;
  logic [31:0] tb_value = '0;
  logic        tb_ready = 1'b1;

  logic        o_busy, o_valid, o_last, o_prime;
  logic [31:0] o_factor, o_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  factor_engine_if #(.WIDTH(8))  if8  ();
  factor_engine_if #(.WIDTH(16)) if16 ();
  factor_engine_if #(.WIDTH(17)) if17 ();

  assign if8.start         = tb_start && (sel == 2'd0);
  assign if8.value         = tb_value[7:0];
  assign if8.factor_ready  = tb_ready;
  assign if16.start        = tb_start && (sel == 2'd1);
  assign if16.value        = tb_value[15:0];
  assign if16.factor_ready = tb_ready;
  assign if17.start        = tb_start && (sel == 2'd2);
  assign if17.value        = tb_value[16:0];
  assign if17.factor_ready = tb_ready;

  factor_engine #(.WIDTH(8))  u_fe8  (.clk(clk), .rst(rst), .fe(if8));
  factor_engine #(.WIDTH(16)) u_fe16 (.clk(clk), .rst(rst), .fe(if16));
  factor_engine #(.WIDTH(17)) u_fe17 (.clk(clk), .rst(rst), .fe(if17));

  // Present the selected instance's outputs on common 32-bit observers.
  always_comb begin
    o_busy = 1'b0; o_valid = 1'b0; o_last = 1'b0; o_prime = 1'b0;
    o_factor = '0; o_count = '0;
    case (sel)
      2'd0: begin
        o_busy = if8.busy; o_valid = if8.factor_valid; o_last = if8.factor_last;
        o_prime = if8.is_prime; o_factor = 32'(if8.factor); o_count = 32'(if8.count);
      end
      2'd1: begin
        o_busy = if16.busy; o_valid = if16.factor_valid; o_last = if16.factor_last;
        o_prime = if16.is_prime; o_factor = 32'(if16.factor); o_count = 32'(if16.count);
      end
      default: begin
        o_busy = if17.busy; o_valid = if17.factor_valid; o_last = if17.factor_last;
        o_prime = if17.is_prime; o_factor = 32'(if17.factor); o_count = 32'(if17.count);
      end
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Start one operand and consume its factor stream. With rnd_ready the
  // consumer stalls at random and spurious starts are thrown at the busy DUT.
  task automatic run_op(input string tag, input int inst, input logic [31:0] v,
                        input fac_t exp, input int n, input logic exp_prime,
                        input bit rnd_ready, input int lat);
    int          idx   = 0;
    int          cyc   = 0;
    int          first = -1;
    logic        held  = 1'b0;
    logic [31:0] hf    = '0;
    logic        hl    = 1'b0;
    logic        hp    = 1'b0;
    @(negedge clk);
    sel      = inst[1:0];
    tb_value = v;
    tb_start = 1'b1;
    tb_ready = 1'b1;
    @(negedge clk);
    tb_start = 1'b0;
    cyc      = 1;
    check({tag, "/busy_after_start"}, 32'(o_busy), 32'd1);
    while (idx < n && cyc < BUDGET) begin
      if (o_valid && first < 0) first = cyc;
      if (held) begin
        check({tag, "/hold_valid"}, 32'(o_valid), 32'd1);
        check({tag, "/hold_factor"}, o_factor, hf);
        check({tag, "/hold_last"}, 32'(o_last), 32'(hl));
        check({tag, "/hold_prime"}, 32'(o_prime), 32'(hp));
      end
      tb_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rnd_ready) begin
        tb_start = ($urandom_range(0, 3) == 0);
        tb_value = 32'd77;
      end
      if (o_valid && tb_ready) begin
        check($sformatf("%s/factor%0d", tag, idx), o_factor, exp[idx]);
        check($sformatf("%s/last%0d", tag, idx), 32'(o_last), 32'(idx == n - 1));
        if (idx == n - 1) check({tag, "/is_prime"}, 32'(o_prime), 32'(exp_prime));
        idx++;
        held = 1'b0;
      end else begin
        held = o_valid;
        hf   = o_factor;
        hl   = o_last;
        hp   = o_prime;
      end
      @(negedge clk);
      cyc++;
    end
    tb_start = 1'b0;
    tb_ready = 1'b1;
    if (idx < n) check({tag, "/timeout_factors_seen"}, 32'(idx), 32'(n));
    check({tag, "/busy_after_last"}, 32'(o_busy), 32'd0);
    check({tag, "/valid_after_last"}, 32'(o_valid), 32'd0);
    check({tag, "/count"}, o_count, 32'(n));
    if (lat >= 0) check({tag, "/first_valid_cycle"}, 32'(first), 32'(lat));
  endtask

  task automatic wait_valid(input string tag);
    int cyc = 0;
    while (!o_valid && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
    end
    if (!o_valid) check({tag, "/timeout_valid"}, 32'(o_valid), 32'd1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "/busy"}, 32'(o_busy), 32'd0);
    check({tag, "/valid"}, 32'(o_valid), 32'd0);
    check({tag, "/factor"}, o_factor, 32'd0);
    check({tag, "/last"}, 32'(o_last), 32'd0);
    check({tag, "/prime"}, 32'(o_prime), 32'd0);
    check({tag, "/count"}, o_count, 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;

    run_op("w8_12",  0, 32'd12,  '{0:2, 1:2, 2:3, default:0}, 3, 1'b0, 1'b0, -1);
    run_op("w8_97",  0, 32'd97,  '{0:97, default:0},          1, 1'b1, 1'b0, -1);
    run_op("w8_2",   0, 32'd2,   '{0:2, default:0},           1, 1'b1, 1'b0, 2);
    run_op("w8_0",   0, 32'd0,   '{0:0, default:0},           1, 1'b0, 1'b0, 1);
    run_op("w8_1",   0, 32'd1,   '{0:1, default:0},           1, 1'b0, 1'b0, 1);
    run_op("w8_255", 0, 32'd255, '{0:3, 1:5, 2:17, default:0}, 3, 1'b0, 1'b1, -1);
    run_op("w8_255b", 0, 32'd255, '{0:3, 1:5, 2:17, default:0}, 3, 1'b0, 1'b1, -1);
    run_op("w16_65521", 1, 32'd65521, '{0:65521, default:0}, 1, 1'b1, 1'b0, -1);
    run_op("w17_65536", 2, 32'd65536, '{default:2}, 16, 1'b0, 1'b0, -1);

    // Abort in the middle of a division.
    @(negedge clk);
    sel = 2'd0; tb_value = 32'd255; tb_start = 1'b1;
    @(negedge clk);
    tb_start = 1'b0;
    repeat (4) @(negedge clk);
    check("midDIV/busy_before_rst", 32'(o_busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_state("rst_midDIV");

    // Abort while the second factor of 12 is stalled in EMIT.
    sel = 2'd0; tb_value = 32'd12; tb_start = 1'b1; tb_ready = 1'b0;
    @(negedge clk);
    tb_start = 1'b0;
    wait_valid("stall1");
    tb_ready = 1'b1;
    @(negedge clk);
    tb_ready = 1'b0;
    wait_valid("stall2");
    repeat (3) @(negedge clk);
    check("stall/valid_held", 32'(o_valid), 32'd1);
    check("stall/count_before_rst", o_count, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tb_ready = 1'b1;
    check_reset_state("rst_stalled");

    run_op("w8_6_after_rst", 0, 32'd6, '{0:2, 1:3, default:0}, 2, 1'b0, 1'b0, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
